multdiv_seq_ctrl: RTL
=====================

// Module: multdiv_seq_ctrl
// PURPOSE
//  Sequencer for the iterative multiply/divide datapath. Accepts one-cycle start
//  strobes, then drives the datapath through a load cycle and N_ITER step cycles.
//  Ends with a one-cycle result-ready pulse.
//  Iteration count is held in a T-flip-flop counter, and the block owns all
//  datapath enables. Sits between the CPU execute stage and the multdiv datapath.
// PARAMETERS
//  N_ITER  32  datapath step cycles per operation (16 for radix-4 multiply builds)
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > N_ITER
// PORTS
//  clk          in   1      clock, posedge
//  clr          in   1      reset, asynchronous, active-high
//  ctrl_mult    in   1      start multiply, one-cycle strobe
//  ctrl_div     in   1      start divide, one-cycle strobe
//  div_by_zero  in   1      from datapath: divisor==0; valid during LOAD cycle
//  busy         out  1      operation in progress (LOAD or RUN)
//  op_div       out  1      registered op select: 1=divide, 0=multiply
//  load_en      out  1      datapath loads operands this cycle
//  step_en      out  1      datapath performs one iteration this cycle
//  iter         out  CNT_W  index of current step, 0..N_ITER-1 while step_en
//  last_iter    out  1      step_en && iter==N_ITER-1
//  result_rdy   out  1      one-cycle pulse: datapath result/exception valid
//  exception    out  1      held with result_rdy; 1 = divide by zero
// BEHAVIOUR
//  States: IDLE, LOAD, RUN, DONE. Reset (clr=1): state=IDLE, iter=0, op_div=0,
//   all other outputs 0, asynchronously.
//  Outputs are decoded from registered state only:
//   load_en = (LOAD); step_en = (RUN); busy = (LOAD|RUN); result_rdy = (DONE).
//  Start: a strobe (ctrl_mult|ctrl_div) sampled at any edge, in any state, moves
//   to LOAD. It also latches op_div=ctrl_div and synchronously clears iter to 0.
//  Restart: a start in LOAD/RUN/DONE aborts the current operation, with no result_rdy
//   for the aborted op. A start sampled in DONE still lets that DONE cycle's
//   result_rdy pulse complete.
//  Both strobes high in the same cycle: multiply wins (op_div=0).
//  LOAD -> RUN, unless op_div && div_by_zero; in that case LOAD -> DONE with exception=1.
//  RUN: iter increments by 1 each cycle. When iter==N_ITER-1, the next state is DONE
//   and iter is cleared. iter never wraps past N_ITER-1.
//  DONE -> IDLE after exactly one cycle. exception is cleared on leaving DONE.
//  Latency: start sampled at edge E. Then load_en is high E..E+1, step_en is high
//   E+1..E+N_ITER+1, and result_rdy is high for the cycle after edge E+N_ITER+1.
//   Start-to-result is N_ITER+2 cycles; div-by-zero is 2 cycles.
//  Strobes in IDLE with neither bit set: no action.
//  div_by_zero is ignored outside LOAD and for multiply.
//  Mid-operation clr: immediate return to reset values; no result_rdy.
// STRUCTURE
//  Shared package (multdiv_pkg): state encodings IDLE/LOAD/RUN/DONE (2-bit),
//   default N_ITER and CNT_W.
//  Sub-module tff_counter #(CNT_W): synchronous up-counter built from toggle
//   flip-flops. Inputs: inc, sclr, clk, clr.
//   Toggle per bit: t[i] = sclr ? q[i] : inc & (&q[i-1:0]); bit 0 uses inc.
//  Controller: 2-bit state register (async clr) plus next-state logic.
//   Also holds the op_div and exception flops.
// TESTING
//  1 Reset: assert clr mid-cycle -> all outputs 0 at once, iter=0, state IDLE.
//  2 Multiply: ctrl_mult for 1 cycle -> load_en 1 cycle, then step_en 32 cycles
//    with iter 0..31 and last_iter at 31, then result_rdy 1 cycle with op_div=0
//    and exception=0.
//  3 Divide by zero: ctrl_div, div_by_zero=1 during LOAD -> no step_en;
//    result_rdy and exception high 2 cycles after the start.
//  4 Restart: ctrl_div, then ctrl_mult at iter=10 -> LOAD again, iter=0, op_div=0;
//    exactly one result_rdy, 34 cycles after the second start.
//  5 Simultaneous start: ctrl_mult=ctrl_div=1 -> op_div=0, normal 34-cycle multiply.
//  6 N_ITER=16, CNT_W=5 build: ctrl_mult -> step_en 16 cycles, result_rdy at start+18;
//    iter never exceeds 15.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding and
// default iteration geometry.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int N_ITER_DEF = 32;
  localparam int CNT_W_DEF  = 6;

endpackage

// File: rtl/multdiv_seq_ctrl_tff_counter.sv
// Synchronous up-counter built from toggle flip-flops; sclr toggles every set
// bit so the counter lands on zero at the next edge.
module tff_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             sclr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] w_carry;
  logic [CNT_W-1:0] w_t;

  // Ripple the all-lower-bits-set term up the chain to form each toggle enable
  always_comb begin
    w_carry    = '0;
    w_t        = '0;
    w_carry[0] = inc;
    for (int i = 1; i < CNT_W; i++) begin
      w_carry[i] = w_carry[i-1] & r_q[i-1];
    end
    for (int i = 0; i < CNT_W; i++) begin
      w_t[i] = sclr ? r_q[i] : w_carry[i];
    end
  end

  // Toggle flip-flop bank
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q <= '0;
    end else begin
      r_q <= r_q ^ w_t;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: LOAD, N_ITER steps,
// then a one-cycle result-ready pulse. Any start strobe restarts the sequence.
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             div_by_zero,
  output logic             busy,
  output logic             op_div,
  output logic             load_en,
  output logic             step_en,
  output logic [CNT_W-1:0] iter,
  output logic             last_iter,
  output logic             result_rdy,
  output logic             exception
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_op_div;
  logic             w_op_div_nxt;
  logic             r_exc;
  logic             w_exc_nxt;
  logic             w_start;
  logic             w_inc;
  logic             w_sclr;
  logic [CNT_W-1:0] w_iter;

  assign w_start = ctrl_mult | ctrl_div;

  // Next-state, op latch and counter control; a start overrides every state
  always_comb begin
    w_state_nxt  = r_state;
    w_op_div_nxt = r_op_div;
    w_exc_nxt    = 1'b0;
    w_inc        = 1'b0;
    w_sclr       = 1'b0;
    if (w_start) begin
      w_state_nxt  = ST_LOAD;
      w_op_div_nxt = ctrl_div & ~ctrl_mult;
      w_sclr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LOAD: begin
          if (r_op_div && div_by_zero) begin
            w_state_nxt = ST_DONE;
            w_exc_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_iter == LAST_ITER) begin
            w_state_nxt = ST_DONE;
            w_sclr      = 1'b1;
          end else begin
            w_inc       = 1'b1;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, op select and exception flag
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_op_div <= 1'b0;
      r_exc    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op_div <= w_op_div_nxt;
      r_exc    <= w_exc_nxt;
    end
  end

  tff_counter #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk  (clk),
    .clr  (clr),
    .inc  (w_inc),
    .sclr (w_sclr),
    .q    (w_iter)
  );

  assign load_en    = (r_state == ST_LOAD);
  assign step_en    = (r_state == ST_RUN);
  assign busy       = load_en | step_en;
  assign result_rdy = (r_state == ST_DONE);
  assign op_div     = r_op_div;
  assign exception  = r_exc;
  assign iter       = w_iter;
  assign last_iter  = step_en & (w_iter == LAST_ITER);

endmodule
